// File: rtl/ma_lsu.sv
// ma_lsu: memory-access stage load/store unit.
// One bus transaction per memory op; load data formatting; MA/WB producer.
`ifndef XMSB
`define XMSB 63
`endif

module ma_lsu #(
  parameter int BUS_AW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [`XMSB:0]    pc,
  input  logic [4:0]        rd,
  input  logic [63:0]       alu_res,
  input  logic [63:0]       sdata,
  input  logic [3:0]        mem_op,
  input  logic              mem_uns,
  output logic              bus_req,
  output logic              bus_we,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [63:0]       bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata,
  input  logic              bus_rerr,
  output logic [`XMSB:0]    pc_out,
  output logic [4:0]        rd_out,
  output logic [63:0]       data_out,
  output logic              stall,
  output logic              trap_en,
  output logic [3:0]        trap_cause,
  output logic [63:0]       trap_tval
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state, state_n;

  logic [`XMSB:0] l_pc;
  logic [4:0]     l_rd;
  logic [63:0]    l_addr;
  logic [63:0]    l_wdata;
  logic [7:0]     l_mask;
  logic [1:0]     l_size;
  logic           l_uns;
  logic           l_st;
  logic           killed;

  logic [1:0]     size;
  logic [2:0]     off;
  logic           is_mem;
  logic           is_st;
  logic           mis;
  logic           accept;
  logic           done;
  logic [63:0]    repl;
  logic [63:0]    lane;
  logic [63:0]    ldata;

  assign size   = mem_op[1:0];
  assign off    = alu_res[2:0];
  assign is_mem = mem_op[3];
  assign is_st  = mem_op[2];
  assign accept = (state == IDLE) && is_mem
                  && !mis && !clear;
  assign done   = (state == WAIT) && bus_rvalid;

  // misalignment and store-lane replication for the incoming op
  always_comb begin
    mis  = 1'b0;
    repl = sdata;
    unique case (size)
      2'd0: begin
        mis  = 1'b0;
        repl = {8{sdata[7:0]}};
      end
      2'd1: begin
        mis  = off[0];
        repl = {4{sdata[15:0]}};
      end
      2'd2: begin
        mis  = |off[1:0];
        repl = {2{sdata[31:0]}};
      end
      default: begin
        mis  = |off;
        repl = sdata;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // capture the accepted op for the duration of the transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_pc    <= '0;
      l_rd    <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
      l_mask  <= '0;
      l_size  <= '0;
      l_uns   <= 1'b0;
      l_st    <= 1'b0;
    end else if (accept) begin
      l_pc    <= pc;
      l_rd    <= rd;
      l_addr  <= alu_res;
      l_wdata <= repl;
      l_size  <= size;
      l_uns   <= mem_uns;
      l_st    <= is_st;
      unique case (size)
        2'd0:    l_mask <= 8'h01 << off;
        2'd1:    l_mask <= 8'h03 << off;
        2'd2:    l_mask <= 8'h0f << off;
        default: l_mask <= 8'hff;
      endcase
    end
  end

  // a flush during a transaction only kills its writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          killed <= 1'b0;
    else if (done)                       killed <= 1'b0;
    else if (state != IDLE && clear)     killed <= 1'b1;
  end

  // select and extend the addressed lane of the response
  always_comb begin
    lane  = bus_rdata >> {l_addr[2:0], 3'b000};
    ldata = lane;
    unique case (l_size)
      2'd0: ldata = l_uns ? {56'd0, lane[7:0]}
                          : {{56{lane[7]}}, lane[7:0]};
      2'd1: ldata = l_uns ? {48'd0, lane[15:0]}
                          : {{48{lane[15]}}, lane[15:0]};
      2'd2: ldata = l_uns ? {32'd0, lane[31:0]}
                          : {{32{lane[31]}}, lane[31:0]};
      default: ldata = lane;
    endcase
  end

  // next state and all stage/bus outputs
  always_comb begin
    state_n    = state;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_wmask  = '0;
    pc_out     = '0;
    rd_out     = '0;
    data_out   = '0;
    stall      = 1'b0;
    trap_en    = 1'b0;
    trap_cause = '0;
    trap_tval  = '0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          pc_out = pc;
          if (!is_mem) begin
            rd_out   = clear ? 5'd0 : rd;
            data_out = alu_res;
          end else if (mis) begin
            trap_en    = !clear;
            trap_cause = is_st ? 4'd6 : 4'd4;
            trap_tval  = alu_res;
          end else if (!clear) begin
            stall   = 1'b1;
            state_n = REQ;
          end
        end
        REQ: begin
          stall     = 1'b1;
          pc_out    = l_pc;
          bus_req   = 1'b1;
          bus_we    = l_st;
          bus_addr  = {l_addr[BUS_AW-1:3], 3'b000};
          bus_wdata = l_st ? l_wdata : 64'd0;
          bus_wmask = l_st ? l_mask : 8'd0;
          if (bus_ready) state_n = WAIT;
        end
        WAIT: begin
          stall  = 1'b1;
          pc_out = l_pc;
          if (bus_rvalid) begin
            stall   = 1'b0;
            state_n = IDLE;
            if (!l_st) data_out = ldata;
            if (!(l_st || killed || clear || bus_rerr))
              rd_out = l_rd;
            if (bus_rerr && !killed && !clear) begin
              trap_en    = 1'b1;
              trap_cause = l_st ? 4'd7 : 4'd5;
              trap_tval  = l_addr;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
